// File: rtl/w_stream_adapter_pkg.sv
// Shared constants and occupancy encoding for the write-side stream adapter.
package w_stream_adapter_pkg;

    localparam int DATASIZE_DEF = 8;
    localparam int CNTSIZE_DEF  = 16;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } occ_e;

endpackage

// File: rtl/w_stream_adapter_if.sv
// Upstream valid/ready stream plus FIFO write-side strobe, grouped as one bundle.
interface w_stream_adapter_if
    import w_stream_adapter_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF
);

    logic                s_valid;
    logic [DATASIZE-1:0] s_data;
    logic                s_ready;
    logic                wfull;
    logic                winc;
    logic [DATASIZE-1:0] wdata;

    // The adapter sits between the upstream producer and the FIFO write port.
    modport slave (
        input  s_valid,
        input  s_data,
        input  wfull,
        output s_ready,
        output winc,
        output wdata
    );

    modport master (
        output s_valid,
        output s_data,
        output wfull,
        input  s_ready,
        input  winc,
        input  wdata
    );

endinterface

// File: rtl/w_stream_adapter_sat_counter.sv
// Event counter with synchronous clear; either wraps or holds at all-ones.
module sat_counter
    import w_stream_adapter_pkg::*;
#(
    parameter int WIDTH = CNTSIZE_DEF
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic             inc,
    input  logic             clr,
    input  logic             sat_en,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && !(sat_en && (&cnt_q))) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/w_stream_adapter.sv
// Two-entry skid buffer feeding the FIFO write port, with write/stall statistics.
// s_ready depends only on registered occupancy so upstream timing never sees wfull.
module w_stream_adapter
    import w_stream_adapter_pkg::*;
#(
    parameter int DATASIZE = DATASIZE_DEF,
    parameter int CNTSIZE  = CNTSIZE_DEF
) (
    input  logic                wclk,
    input  logic                wrst_n,
    w_stream_adapter_if.slave   bus,
    input  logic                clr_stats,
    output logic [CNTSIZE-1:0]  word_cnt,
    output logic [CNTSIZE-1:0]  stall_cnt
);

    occ_e                count_q;
    occ_e                count_d;
    logic [DATASIZE-1:0] head_q;
    logic [DATASIZE-1:0] head_d;
    logic [DATASIZE-1:0] tail_q;
    logic [DATASIZE-1:0] tail_d;

    logic s_ready;
    logic winc;
    logic push;
    logic pop;
    logic stall;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            count_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;

        unique case ({push, pop})
            2'b10:   count_d = (count_q == EMPTY) ? ONE : TWO;
            2'b01:   count_d = (count_q == TWO) ? ONE : EMPTY;
            default: count_d = count_q;
        endcase

        // A push during a pop at occupancy one lands directly in the freed head.
        if (pop) begin
            if (count_q == TWO) begin
                head_d = tail_q;
            end else if (push) begin
                head_d = bus.s_data;
            end
        end else if (push) begin
            if (count_q == EMPTY) begin
                head_d = bus.s_data;
            end else begin
                tail_d = bus.s_data;
            end
        end
    end

    always_comb begin
        s_ready = (count_q != TWO);
        winc    = (count_q != EMPTY) && !bus.wfull;
        stall   = (count_q != EMPTY) && bus.wfull;
        push    = bus.s_valid && s_ready;
        pop     = winc;
    end

    assign bus.s_ready = s_ready;
    assign bus.winc    = winc;
    assign bus.wdata   = head_q;

    sat_counter #(.WIDTH(CNTSIZE)) u_word_cnt (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .inc    (winc),
        .clr    (clr_stats),
        .sat_en (1'b0),
        .cnt    (word_cnt)
    );

    sat_counter #(.WIDTH(CNTSIZE)) u_stall_cnt (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .inc    (stall),
        .clr    (clr_stats),
        .sat_en (1'b1),
        .cnt    (stall_cnt)
    );

endmodule

// File: tb/tb_w_stream_adapter.sv
// Directed and scoreboard checks of the write-side stream adapter.
module tb_w_stream_adapter;

    logic        wclk;
    logic        wrst_n;
    logic        clr_stats;
    logic        clr_stats4;
    logic [15:0] word_cnt;
    logic [15:0] stall_cnt;
    logic [3:0]  word_cnt4;
    logic [3:0]  stall_cnt4;

    int checks;
    int failures;

    w_stream_adapter_if #(.DATASIZE(8)) bus ();
    w_stream_adapter_if #(.DATASIZE(8)) bus4 ();

    w_stream_adapter #(.DATASIZE(8), .CNTSIZE(16)) dut (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .bus       (bus.slave),
        .clr_stats (clr_stats),
        .word_cnt  (word_cnt),
        .stall_cnt (stall_cnt)
    );

    w_stream_adapter #(.DATASIZE(8), .CNTSIZE(4)) dut4 (
        .wclk      (wclk),
        .wrst_n    (wrst_n),
        .bus       (bus4.slave),
        .clr_stats (clr_stats4),
        .word_cnt  (word_cnt4),
        .stall_cnt (stall_cnt4)
    );

    initial begin
        wclk = 1'b0;
        forever #5 wclk = ~wclk;
    end

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic test_reset();
        wrst_n = 1'b0;
        clr_stats = 1'b0;
        clr_stats4 = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data = 8'h00;
        bus.wfull = 1'b0;
        bus4.s_valid = 1'b0;
        bus4.s_data = 8'h00;
        bus4.wfull = 1'b0;
        #3;
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", bus.s_ready); end
        checks++; if (bus.winc !== 1'b0) begin failures++; $display("FAIL reset_winc got=%b exp=0", bus.winc); end
        checks++; if (bus.wdata !== 8'h00) begin failures++; $display("FAIL reset_wdata got=%h exp=00", bus.wdata); end
        checks++; if (word_cnt !== 16'h0) begin failures++; $display("FAIL reset_word_cnt got=%h exp=0", word_cnt); end
        checks++; if (stall_cnt !== 16'h0) begin failures++; $display("FAIL reset_stall_cnt got=%h exp=0", stall_cnt); end
        checks++; if (stall_cnt4 !== 4'h0) begin failures++; $display("FAIL reset_stall_cnt4 got=%h exp=0", stall_cnt4); end
        tick();
        tick();
        wrst_n = 1'b1;
        tick();
    endtask

    task automatic test_streaming();
        for (int i = 0; i < 18; i++) begin
            bus.s_valid = (i < 16);
            bus.s_data = 8'(i + 1);
            #1;
            checks++;
            if (bus.winc !== ((i >= 1) && (i <= 16))) begin
                failures++;
                $display("FAIL stream_winc cyc=%0d got=%b exp=%b", i, bus.winc, ((i >= 1) && (i <= 16)));
            end
            if ((i >= 1) && (i <= 16)) begin
                checks++;
                if (bus.wdata !== 8'(i)) begin
                    failures++;
                    $display("FAIL stream_wdata cyc=%0d got=%h exp=%h", i, bus.wdata, 8'(i));
                end
            end
            checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL stream_s_ready cyc=%0d got=%b exp=1", i, bus.s_ready); end
            tick();
        end
        checks++; if (word_cnt !== 16'd16) begin failures++; $display("FAIL stream_word_cnt got=%0d exp=16", word_cnt); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL stream_stall_cnt got=%0d exp=0", stall_cnt); end
    endtask

    task automatic test_backpressure();
        clr_stats = 1'b1;
        tick();
        clr_stats = 1'b0;
        checks++; if (word_cnt !== 16'd0) begin failures++; $display("FAIL bp_clr_word_cnt got=%0d exp=0", word_cnt); end

        bus.wfull = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data = 8'hA1;
        #1;
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready0 got=%b exp=1", bus.s_ready); end
        checks++; if (bus.winc !== 1'b0) begin failures++; $display("FAIL bp_winc0 got=%b exp=0", bus.winc); end
        tick();
        bus.s_data = 8'hA2;
        #1;
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready1 got=%b exp=1", bus.s_ready); end
        checks++; if (bus.winc !== 1'b0) begin failures++; $display("FAIL bp_winc1 got=%b exp=0", bus.winc); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL bp_stall1 got=%0d exp=0", stall_cnt); end
        tick();
        bus.s_data = 8'hA3;
        #1;
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready2 got=%b exp=0", bus.s_ready); end
        checks++; if (stall_cnt !== 16'd1) begin failures++; $display("FAIL bp_stall2 got=%0d exp=1", stall_cnt); end
        tick();
        #1;
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready3 got=%b exp=0", bus.s_ready); end
        checks++; if (bus.wdata !== 8'hA1) begin failures++; $display("FAIL bp_head_hold got=%h exp=a1", bus.wdata); end
        checks++; if (stall_cnt !== 16'd2) begin failures++; $display("FAIL bp_stall3 got=%0d exp=2", stall_cnt); end
        tick();
        bus.wfull = 1'b0;
        #1;
        checks++; if (bus.winc !== 1'b1) begin failures++; $display("FAIL bp_winc4 got=%b exp=1", bus.winc); end
        checks++; if (bus.wdata !== 8'hA1) begin failures++; $display("FAIL bp_wdata4 got=%h exp=a1", bus.wdata); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL bp_ready4 got=%b exp=0", bus.s_ready); end
        checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL bp_stall4 got=%0d exp=3", stall_cnt); end
        tick();
        #1;
        checks++; if (bus.winc !== 1'b1) begin failures++; $display("FAIL bp_winc5 got=%b exp=1", bus.winc); end
        checks++; if (bus.wdata !== 8'hA2) begin failures++; $display("FAIL bp_wdata5 got=%h exp=a2", bus.wdata); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL bp_ready5 got=%b exp=1", bus.s_ready); end
        tick();
        bus.s_valid = 1'b0;
        #1;
        checks++; if (bus.winc !== 1'b1) begin failures++; $display("FAIL bp_winc6 got=%b exp=1", bus.winc); end
        checks++; if (bus.wdata !== 8'hA3) begin failures++; $display("FAIL bp_wdata6 got=%h exp=a3", bus.wdata); end
        tick();
        #1;
        checks++; if (bus.winc !== 1'b0) begin failures++; $display("FAIL bp_winc7 got=%b exp=0", bus.winc); end
        checks++; if (word_cnt !== 16'd3) begin failures++; $display("FAIL bp_word_cnt got=%0d exp=3", word_cnt); end
        checks++; if (stall_cnt !== 16'd3) begin failures++; $display("FAIL bp_stall_final got=%0d exp=3", stall_cnt); end
    endtask

    task automatic test_simultaneous();
        bus.wfull = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data = 8'h33;
        tick();
        bus.s_data = 8'h55;
        #1;
        checks++; if (bus.winc !== 1'b1) begin failures++; $display("FAIL sim_winc0 got=%b exp=1", bus.winc); end
        checks++; if (bus.wdata !== 8'h33) begin failures++; $display("FAIL sim_wdata0 got=%h exp=33", bus.wdata); end
        tick();
        bus.s_valid = 1'b0;
        #1;
        checks++; if (bus.winc !== 1'b1) begin failures++; $display("FAIL sim_winc1 got=%b exp=1", bus.winc); end
        checks++; if (bus.wdata !== 8'h55) begin failures++; $display("FAIL sim_wdata1 got=%h exp=55", bus.wdata); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL sim_ready1 got=%b exp=1", bus.s_ready); end
        tick();
        #1;
        checks++; if (bus.winc !== 1'b0) begin failures++; $display("FAIL sim_winc2 got=%b exp=0", bus.winc); end
    endtask

    task automatic test_saturation();
        bus4.wfull = 1'b1;
        bus4.s_valid = 1'b1;
        bus4.s_data = 8'h77;
        tick();
        bus4.s_valid = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        checks++; if (stall_cnt4 !== 4'd14) begin failures++; $display("FAIL sat_stall14 got=%0d exp=14", stall_cnt4); end
        for (int i = 0; i < 6; i++) tick();
        checks++; if (stall_cnt4 !== 4'hF) begin failures++; $display("FAIL sat_stall20 got=%h exp=f", stall_cnt4); end
        checks++; if (word_cnt4 !== 4'd0) begin failures++; $display("FAIL sat_word0 got=%0d exp=0", word_cnt4); end
        bus4.wfull = 1'b0;
        tick();
        checks++; if (word_cnt4 !== 4'd1) begin failures++; $display("FAIL sat_word1 got=%0d exp=1", word_cnt4); end
        checks++; if (stall_cnt4 !== 4'hF) begin failures++; $display("FAIL sat_stall_hold got=%h exp=f", stall_cnt4); end
        clr_stats4 = 1'b1;
        tick();
        clr_stats4 = 1'b0;
        checks++; if (stall_cnt4 !== 4'd0) begin failures++; $display("FAIL sat_clr_stall got=%0d exp=0", stall_cnt4); end
        for (int i = 0; i < 17; i++) begin
            bus4.s_valid = 1'b1;
            bus4.s_data = 8'(i);
            tick();
        end
        bus4.s_valid = 1'b0;
        tick();
        tick();
        checks++; if (word_cnt4 !== 4'd1) begin failures++; $display("FAIL wrap_word17 got=%0d exp=1", word_cnt4); end

        bus4.s_valid = 1'b1;
        bus4.s_data = 8'hC0;
        tick();
        bus4.s_data = 8'hC1;
        clr_stats4 = 1'b1;
        #1;
        checks++; if (bus4.winc !== 1'b1) begin failures++; $display("FAIL clr_winc got=%b exp=1", bus4.winc); end
        tick();
        bus4.s_valid = 1'b0;
        clr_stats4 = 1'b0;
        checks++; if (word_cnt4 !== 4'd0) begin failures++; $display("FAIL clr_word got=%0d exp=0", word_cnt4); end
        #1;
        checks++; if (bus4.wdata !== 8'hC1) begin failures++; $display("FAIL clr_datapath got=%h exp=c1", bus4.wdata); end
        tick();
        checks++; if (word_cnt4 !== 4'd1) begin failures++; $display("FAIL clr_after got=%0d exp=1", word_cnt4); end
    endtask

    task automatic test_reset_mid();
        bus.wfull = 1'b1;
        bus.s_valid = 1'b1;
        bus.s_data = 8'hB1;
        tick();
        bus.s_data = 8'hB2;
        tick();
        bus.s_valid = 1'b0;
        bus.wfull = 1'b0;
        #1;
        checks++; if (bus.winc !== 1'b1) begin failures++; $display("FAIL rmid_pre_winc got=%b exp=1", bus.winc); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL rmid_pre_ready got=%b exp=0", bus.s_ready); end
        wrst_n = 1'b0;
        #1;
        checks++; if (bus.winc !== 1'b0) begin failures++; $display("FAIL rmid_winc got=%b exp=0", bus.winc); end
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL rmid_ready got=%b exp=1", bus.s_ready); end
        checks++; if (word_cnt !== 16'd0) begin failures++; $display("FAIL rmid_word got=%0d exp=0", word_cnt); end
        checks++; if (stall_cnt !== 16'd0) begin failures++; $display("FAIL rmid_stall got=%0d exp=0", stall_cnt); end
        tick();
        wrst_n = 1'b1;
        tick();
        checks++; if (bus.winc !== 1'b0) begin failures++; $display("FAIL rmid_post_winc got=%b exp=0", bus.winc); end
        bus.s_valid = 1'b1;
        bus.s_data = 8'hC7;
        tick();
        bus.s_valid = 1'b0;
        #1;
        checks++; if (bus.winc !== 1'b1) begin failures++; $display("FAIL rmid_first_winc got=%b exp=1", bus.winc); end
        checks++; if (bus.wdata !== 8'hC7) begin failures++; $display("FAIL rmid_first_wdata got=%h exp=c7", bus.wdata); end
        tick();
    endtask

    task automatic test_random();
        logic [7:0] sb[$];
        logic       exp_ready;
        logic       exp_winc;
        int         busy;
        int         writes;
        writes = 0;
        for (int i = 0; i < 10000; i++) begin
            busy = ((i / 500) % 2 == 1) ? 3 : 1;
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.wfull = ($urandom_range(0, 3) < busy);
            bus.s_data = 8'($urandom_range(0, 255));
            #1;
            exp_ready = (sb.size() < 2);
            exp_winc = (sb.size() > 0) && !bus.wfull;
            checks++;
            if (bus.s_ready !== exp_ready) begin
                failures++;
                $display("FAIL rand_ready cyc=%0d got=%b exp=%b", i, bus.s_ready, exp_ready);
            end
            checks++;
            if (bus.winc !== exp_winc) begin
                failures++;
                $display("FAIL rand_winc cyc=%0d got=%b exp=%b wfull=%b", i, bus.winc, exp_winc, bus.wfull);
            end
            if (exp_winc) begin
                checks++;
                if (bus.wdata !== sb[0]) begin
                    failures++;
                    $display("FAIL rand_wdata cyc=%0d got=%h exp=%h", i, bus.wdata, sb[0]);
                end
                void'(sb.pop_front());
                writes++;
            end
            if (bus.s_valid && exp_ready) sb.push_back(bus.s_data);
            tick();
        end
        bus.s_valid = 1'b0;
        bus.wfull = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (sb.size() > 0) begin
                checks++;
                if ((bus.winc !== 1'b1) || (bus.wdata !== sb[0])) begin
                    failures++;
                    $display("FAIL rand_drain got=%b/%h exp=1/%h", bus.winc, bus.wdata, sb[0]);
                end
                void'(sb.pop_front());
                writes++;
            end
            tick();
        end
        checks++;
        if (bus.winc !== 1'b0) begin failures++; $display("FAIL rand_empty_winc got=%b exp=0", bus.winc); end
        checks++;
        if (word_cnt !== 16'(writes + 1)) begin
            failures++;
            $display("FAIL rand_word_cnt got=%0d exp=%0d", word_cnt, writes + 1);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/w_stream_adapter.md
W_STREAM_ADAPTER -- requirements
Module: w_stream_adapter

Interface
REQ-001 SHALL have parameter DATASIZE, default 8, payload width in bits.
REQ-002 SHALL have parameter CNTSIZE, default 16, statistics counter width in bits.
REQ-003 SHALL have port wclk  input  1  write-domain clock; all state sampled on its rising edge.
REQ-004 SHALL have port wrst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port s_valid  input  1  upstream word present.
REQ-006 SHALL have port s_data  input  DATASIZE  upstream word.
REQ-007 SHALL have port s_ready  output  1  adapter can accept a word this cycle.
REQ-008 SHALL have port wfull  input  1  FIFO full, from the write-pointer control in the wclk domain.
REQ-009 SHALL have port winc  output  1  write strobe to the FIFO.
REQ-010 SHALL have port wdata  output  DATASIZE  word written to FIFO RAM when winc=1.
REQ-011 SHALL have port clr_stats  input  1  synchronous clear of the statistics counters.
REQ-012 SHALL have port word_cnt  output  CNTSIZE  words written to the FIFO; wraps modulo 2^CNTSIZE.
REQ-013 SHALL have port stall_cnt  output  CNTSIZE  cycles with data pending and wfull=1; saturates at all-ones.

Function
REQ-014 SHALL hold a 2-entry skid buffer (head, tail) with a 2-bit occupancy count of 0..2.
REQ-015 SHALL drive s_ready = (count<2), from registered state only, with no combinational path from wfull or s_valid.
REQ-016 SHALL accept (push) when s_valid=1 and s_ready=1.
REQ-017 SHALL drive winc = (count>0) and !wfull, combinationally; wdata SHALL equal the head entry.
REQ-018 SHALL pop the head when winc=1; the tail moves to the head in the same edge.
REQ-019 SHALL, on simultaneous push and pop: count unchanged; the new word goes to head if count=1 (after pop), else to tail.
REQ-020 SHALL have a latency of 1 cycle, s_data accepted at edge N to winc/wdata valid after edge N, provided wfull=0.
REQ-021 SHALL preserve word order strictly: no loss, no duplication, across any wfull pattern.
REQ-022 SHALL hold head and tail stable while wfull=1 (winc=0).
REQ-023 SHALL NOT change the data or ordering of the data path when s_valid toggles while s_ready=0; no push occurs in that case.
REQ-024 SHALL increment word_cnt by 1 on each cycle with winc=1, wrapping from all-ones to 0.
REQ-025 SHALL increment stall_cnt on each cycle with count>0 and wfull=1, holding at all-ones.
REQ-026 SHALL give clr_stats=1 priority over increments: both counters go to 0 at that edge; the data path is unaffected.
REQ-027 SHALL sustain one word per cycle indefinitely while wfull=0 and s_valid=1.

Reset
REQ-028 SHALL, when wrst_n=0, asynchronously force count=0, head=0, tail=0, word_cnt=0, stall_cnt=0.
REQ-029 SHALL, during reset: s_ready=1 (count=0), winc=0, wdata=0.
REQ-030 SHALL discard buffered words on reset mid-operation; no winc in the cycle following deassertion.
REQ-031 SHALL release reset synchronously to wclk; it is the integrator's responsibility to synchronise deassertion externally.

Structure
REQ-032 SHALL place the default DATASIZE and CNTSIZE constants and the occupancy encoding (EMPTY=0, ONE=1, TWO=2) in the shared asy_FIFO package.
REQ-033 SHALL use one sub-module, sat_counter (width-parameterised, with inc, clr and sat-enable), instantiated twice; sat-enable=0 for word_cnt and 1 for stall_cnt.
REQ-034 SHALL contain no clock-domain crossing logic; the whole block is in the wclk domain.

Verification
REQ-035 Streaming: s_valid=1 with data 0x01..0x10 on consecutive cycles, wfull=0 -> winc high 16 consecutive cycles starting 1 cycle later, wdata 0x01..0x10 in order, word_cnt=16, stall_cnt=0.
REQ-036 Backpressure: push 0xA1,0xA2,0xA3 with wfull=1 from cycle 1 -> count=2, s_ready=0 after 2 pushes, 0xA3 held upstream, stall_cnt increments each full cycle; release wfull -> 0xA1,0xA2,0xA3 written in order.
REQ-037 Simultaneous push/pop: count=1, wfull=0, push 0x55 -> winc=1 with old head, next cycle wdata=0x55, count stays 1.
REQ-038 Saturation/wrap: CNTSIZE=4, 20 stall cycles -> stall_cnt=0xF; 17 writes -> word_cnt=1; clr_stats during a write -> both counters 0.
REQ-039 Reset mid-operation: count=2, assert wrst_n=0 asynchronously -> winc=0, s_ready=1, counters 0 immediately; after release, the first winc carries the first post-reset word.
REQ-040 Random: 10k cycles of random s_valid and wfull -> scoreboard matches the order of FIFO-written words, and winc is never 1 while wfull=1.
